gf2m8_mac_gated: RTL and testbench



---
 rtl/gf2m8_mac_gated.sv | 104 ++++++++++
 tb/tb_gf2m8_mac_gated.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/gf2m8_mac_gated.sv
`default_nettype none
// gf2m8_mac_gated: GF(2^8) multiplier with a clock-gated load/accumulate result register.
// Optional macro GF2M8_ICG_EN selects a latch-based clock gate instead of a flop load-enable.

`ifdef GF2M8_ICG_EN
module gf2m8_icg (
  input  logic clk,
  input  logic en,
  output logic gclk
);
  logic en_lat;

  // Enable is captured only while clk is low, so gclk never glitches during the high phase.
  always_latch begin
    if (!clk) en_lat <= en;
  end

  assign gclk = clk & en_lat;
endmodule
`endif

module gf2m8_mac_gated #(
  parameter logic [8:0] POLY = 9'h11D
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       ena,
  input  logic       acc,
  input  logic       clr,
  input  logic [7:0] x,
  input  logic [7:0] y,
  output logic [7:0] z,
  output logic [7:0] q,
  output logic       q_vld
);
  logic [14:0] prod;
  logic [7:0]  q_q, q_d;
  logic        vld_q, vld_d;
  logic        gate_en;

  always_comb begin
    prod = '0;
    for (int i = 0; i < 8; i++) begin
      for (int j = 0; j < 8; j++) begin
        prod[i+j] = prod[i+j] ^ (x[i] & y[j]);
      end
    end
    // Fold the high bits down from the top so each reduction clears the bit it targets.
    for (int k = 14; k >= 8; k--) begin
      if (prod[k]) prod = prod ^ (15'(POLY) << (k - 8));
    end
    z = prod[7:0];
  end

  always_comb begin
    q_d   = q_q;
    vld_d = 1'b0;
    if (clr) begin
      q_d   = '0;
      vld_d = 1'b0;
    end else if (ena) begin
      q_d   = acc ? (q_q ^ z) : z;
      vld_d = 1'b1;
    end
  end

  // q_vld is part of the enable so the edge that drops it is still clocked.
  assign gate_en = ena | clr | ~rstn | vld_q;

`ifdef GF2M8_ICG_EN
  logic gclk;

  gf2m8_icg u_icg (
    .clk  (clk),
    .en   (gate_en),
    .gclk (gclk)
  );

  always_ff @(posedge gclk) begin
    if (!rstn) begin
      q_q   <= '0;
      vld_q <= 1'b0;
    end else begin
      q_q   <= q_d;
      vld_q <= vld_d;
    end
  end
`else
  always_ff @(posedge clk) begin
    if (!rstn) begin
      q_q   <= '0;
      vld_q <= 1'b0;
    end else if (gate_en) begin
      q_q   <= q_d;
      vld_q <= vld_d;
    end
  end
`endif

  assign q     = q_q;
  assign q_vld = vld_q;
endmodule

`default_nettype wire

// File: tb/tb_gf2m8_mac_gated.sv
`default_nettype none
// Bench for gf2m8_mac_gated: vector table, exhaustive z, directed sequences, random scoreboard.
module tb_gf2m8_mac_gated;
  logic       clk = 1'b0;
  logic       rstn, ena, acc, clr;
  logic [7:0] x, y;
  logic [7:0] z, q;
  logic       q_vld;

  int checks = 0;
  int errors = 0;

  logic [7:0] qm;
  logic       vm;

  gf2m8_mac_gated #(.POLY(9'h11D)) dut (
    .clk   (clk),
    .rstn  (rstn),
    .ena   (ena),
    .acc   (acc),
    .clr   (clr),
    .x     (x),
    .y     (y),
    .z     (z),
    .q     (q),
    .q_vld (q_vld)
  );

  always #5 clk = ~clk;

  // Shift-and-add multiply: doubles a each step and reduces immediately.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] aa;
    logic [7:0] r;
    aa = a;
    r  = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) r = r ^ aa;
      aa = aa[7] ? ((aa << 1) ^ 8'h1D) : (aa << 1);
    end
    return r;
  endfunction

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %02h expected %02h", nm, act, exp);
    end
  endtask

  // Drive one cycle, advance the model at the edge, and compare after the edge.
  task automatic cyc(input logic r, input logic e, input logic a, input logic c,
                     input logic [7:0] xi, input logic [7:0] yi);
    rstn = r; ena = e; acc = a; clr = c; x = xi; y = yi;
    #1;
    chk("z_pre", z, gmul(xi, yi));
    @(posedge clk);
    if (!r || c) begin
      qm = 8'h00; vm = 1'b0;
    end else if (e) begin
      qm = a ? (qm ^ gmul(xi, yi)) : gmul(xi, yi);
      vm = 1'b1;
    end else begin
      vm = 1'b0;
    end
    #1;
    chk("q_model", q, qm);
    chk("vld_model", {7'b0, q_vld}, {7'b0, vm});
  endtask

  typedef struct {
    logic [7:0] xv;
    logic [7:0] yv;
    logic [7:0] zv;
  } vec_t;

  initial begin
    vec_t tbl[6];
    tbl[0] = '{8'h02, 8'h80, 8'h1D};
    tbl[1] = '{8'h80, 8'h80, 8'h13};
    tbl[2] = '{8'h03, 8'h03, 8'h05};
    tbl[3] = '{8'hFF, 8'h01, 8'hFF};
    tbl[4] = '{8'h02, 8'h8E, 8'h01};
    tbl[5] = '{8'h00, 8'hA5, 8'h00};

    rstn = 1'b0; ena = 1'b0; acc = 1'b0; clr = 1'b0; x = 8'h00; y = 8'h00;
    qm = 8'h00; vm = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_q", q, 8'h00);
    chk("reset_vld", {7'b0, q_vld}, 8'h00);

    for (int i = 0; i < 6; i++) begin
      x = tbl[i].xv; y = tbl[i].yv;
      #1;
      chk("z_table", z, tbl[i].zv);
    end

    for (int a = 0; a < 256; a++) begin
      for (int b = 0; b < 256; b++) begin
        x = 8'(a); y = 8'(b);
        #1;
        chk("z_exh", z, gmul(8'(a), 8'(b)));
      end
    end

    @(negedge clk);
    // Load then idle
    cyc(1, 1, 0, 0, 8'h80, 8'h80);
    chk("load_q", q, 8'h13);
    chk("load_vld", {7'b0, q_vld}, 8'h01);
    cyc(1, 0, 0, 0, 8'h00, 8'h00);
    chk("hold_q", q, 8'h13);
    chk("hold_vld", {7'b0, q_vld}, 8'h00);

    // Accumulate chain
    cyc(1, 1, 0, 0, 8'h02, 8'h80);
    chk("acc0_q", q, 8'h1D);
    cyc(1, 1, 1, 0, 8'h03, 8'h03);
    chk("acc1_q", q, 8'h18);
    cyc(1, 1, 1, 0, 8'h02, 8'h8E);
    chk("acc2_q", q, 8'h19);

    // clr beats ena
    cyc(1, 1, 0, 1, 8'hFF, 8'h01);
    chk("clr_q", q, 8'h00);
    chk("clr_vld", {7'b0, q_vld}, 8'h00);

    // Reset mid-accumulation
    cyc(1, 1, 0, 0, 8'h02, 8'h80);
    cyc(1, 1, 1, 0, 8'h03, 8'h03);
    chk("pre_rst_q", q, 8'h18);
    cyc(0, 1, 1, 0, 8'h55, 8'h77);
    chk("rst_q", q, 8'h00);
    chk("rst_vld", {7'b0, q_vld}, 8'h00);
    cyc(1, 0, 0, 0, 8'h12, 8'h34);
    chk("post_rst_q", q, 8'h00);
    chk("post_rst_vld", {7'b0, q_vld}, 8'h00);

    for (int n = 0; n < 3000; n++) begin
      cyc(($urandom_range(0, 99) >= 3),
          ($urandom_range(0, 99) < 60),
          1'($urandom),
          ($urandom_range(0, 99) < 10),
          8'($urandom), 8'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
